// File: rtl/mtx_burst_ctrl.sv
// mtx_burst_ctrl: sequences N bursts of B phase beats separated by G srst cycles
// for the multi-tone phase/DDS generator. The generator is held in soft reset
// whenever no burst is running, so every burst starts from the start phase.
// Build option: define MTX_BURST_STATS_EN to add the stall_cnt output.
module mtx_burst_ctrl #(
  parameter int unsigned LEN_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned GAP_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] cfg_burst_len,
  input  logic [CNT_WIDTH-1:0] cfg_n_bursts,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  output logic                 gen_srst,
  output logic                 phase_tvalid,
  output logic                 phase_tlast,
  input  logic                 phase_tready,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] burst_idx
`ifdef MTX_BURST_STATS_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] nb_q, nb_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic [GAP_WIDTH-1:0] gcnt_q, gcnt_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic                 srst_q, srst_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abrt_q, abrt_d;

  logic                 accept;
  logic                 fire;
  logic                 gap_end;

  assign accept  = start && !abort && (cfg_burst_len != '0) && (cfg_n_bursts != '0);
  assign fire    = valid_q && phase_tready;
  // G==0 is treated as a one-cycle gap
  assign gap_end = (gap_q == '0) || (gcnt_q == gap_q - GAP_WIDTH'(1));

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    nb_d    = nb_q;
    gap_d   = gap_q;
    beat_d  = beat_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    srst_d  = 1'b1;
    valid_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    abrt_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d   = cfg_burst_len;
          nb_d    = cfg_n_bursts;
          gap_d   = cfg_gap;
          beat_d  = '0;
          gcnt_d  = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        pend_d = pend_q | abort;
        if (fire) begin
          beat_d = beat_q + LEN_WIDTH'(1);
          if (last_q) begin
            if (pend_q) begin
              abrt_d  = 1'b1;
              state_d = S_IDLE;
            end else if (idx_q == nb_q - CNT_WIDTH'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              idx_d   = idx_q + CNT_WIDTH'(1);
              gcnt_d  = '0;
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (abort || pend_q) begin
          abrt_d  = 1'b1;
          state_d = S_IDLE;
        end else if (gap_end) begin
          beat_d  = '0;
          state_d = S_RUN;
        end else begin
          gcnt_d = gcnt_q + GAP_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) begin
      pend_d = 1'b0;
    end
    if (state_d == S_RUN) begin
      srst_d  = 1'b0;
      valid_d = 1'b1;
      last_d  = pend_d || (beat_d == len_d - LEN_WIDTH'(1));
    end
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      nb_q    <= '0;
      gap_q   <= '0;
      beat_q  <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      srst_q  <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      nb_q    <= nb_d;
      gap_q   <= gap_d;
      beat_q  <= beat_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      srst_q  <= srst_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
    end
  end

  assign gen_srst     = srst_q;
  assign phase_tvalid = valid_q;
  assign phase_tlast  = last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = abrt_q;
  assign burst_idx    = idx_q;

`ifdef MTX_BURST_STATS_EN
  logic [31:0] stall_q;

  // Saturating count of RUN cycles where the generator withheld tready
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && accept) begin
      stall_q <= '0;
    end else if (state_q == S_RUN && !phase_tready && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mtx_burst_ctrl.sv
// Self-checking bench for mtx_burst_ctrl: directed scenarios plus random traffic,
// all checked cycle by cycle against a burst-level behavioural model.
// Honours MTX_BURST_STATS_EN the same way as the design.
module tb_mtx_burst_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_burst_len = '0;
  logic [15:0] cfg_n_bursts = '0;
  logic [23:0] cfg_gap = '0;
  logic        gen_srst;
  logic        phase_tvalid;
  logic        phase_tlast;
  logic        phase_tready = 1'b1;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] burst_idx;
`ifdef MTX_BURST_STATS_EN
  logic [31:0] stall_cnt;
`endif

  mtx_burst_ctrl #(.LEN_WIDTH(32), .CNT_WIDTH(16), .GAP_WIDTH(24)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .abort         (abort),
    .cfg_burst_len (cfg_burst_len),
    .cfg_n_bursts  (cfg_n_bursts),
    .cfg_gap       (cfg_gap),
    .gen_srst      (gen_srst),
    .phase_tvalid  (phase_tvalid),
    .phase_tlast   (phase_tlast),
    .phase_tready  (phase_tready),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .burst_idx     (burst_idx)
`ifdef MTX_BURST_STATS_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Burst-level reference model
  bit              m_busy = 0;
  bit              m_run  = 0;
  bit              m_ab   = 0;
  bit              m_done = 0;
  bit              m_abrt = 0;
  longint unsigned m_beats_left = 0;
  longint unsigned m_bursts_left = 0;
  longint unsigned m_gap_left = 0;
  longint unsigned m_len = 0;
  longint unsigned m_gap = 0;
  longint unsigned m_idx = 0;
  longint unsigned m_stall = 0;

  // Observed per-scenario statistics
  int unsigned beats, lasts, gapcyc, dones, aborts, done_at, k;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_end(input bit was_abort);
    m_busy = 0;
    m_run  = 0;
    m_ab   = 0;
    if (was_abort) m_abrt = 1;
    else           m_done = 1;
  endtask

  task automatic model_update(input bit st, input bit ab, input bit rn, input bit rdy);
    bit last;
    m_done = 0;
    m_abrt = 0;
    if (!rn) begin
      m_busy  = 0;
      m_run   = 0;
      m_ab    = 0;
      m_idx   = 0;
      m_stall = 0;
    end else if (!m_busy) begin
      if (st && !ab && cfg_burst_len != 0 && cfg_n_bursts != 0) begin
        m_busy        = 1;
        m_run         = 1;
        m_ab          = 0;
        m_len         = cfg_burst_len;
        m_beats_left  = cfg_burst_len;
        m_bursts_left = cfg_n_bursts;
        m_gap         = (cfg_gap == 0) ? 1 : cfg_gap;
        m_idx         = 0;
        m_stall       = 0;
      end
    end else if (m_run) begin
      if (!rdy && m_stall != 64'hFFFF_FFFF) m_stall++;
      if (rdy) begin
        last = (m_beats_left == 1) || m_ab;
        m_beats_left--;
        if (last && m_ab) model_end(1);
        else if (last && m_bursts_left == 1) model_end(0);
        else if (last) begin
          m_run = 0;
          m_gap_left = m_gap;
          m_bursts_left--;
          m_idx++;
          m_ab = ab;
        end else m_ab = m_ab | ab;
      end else m_ab = m_ab | ab;
    end else begin
      if (ab || m_ab) model_end(1);
      else begin
        m_gap_left--;
        if (m_gap_left == 0) begin
          m_run = 1;
          m_beats_left = m_len;
        end
      end
    end
  endtask

  task automatic clear_stats();
    beats = 0; lasts = 0; gapcyc = 0; dones = 0; aborts = 0; done_at = 0; k = 0;
  endtask

  // One clock: drive inputs, advance model, check all outputs after the edge
  task automatic step(input bit st, input bit ab, input bit rn, input bit rdy);
    start = st;
    abort = ab;
    resetn = rn;
    phase_tready = rdy;
    if (rn && phase_tvalid && rdy) begin
      beats++;
      if (phase_tlast) lasts++;
    end
    model_update(st, ab, rn, rdy);
    @(posedge clk);
    #1;
    chk("srst",   gen_srst,     !m_run);
    chk("tvalid", phase_tvalid, m_run);
    chk("tlast",  phase_tlast,  m_run && (m_beats_left == 1 || m_ab));
    chk("busy",   busy,         m_busy);
    chk("done",   done,         m_done);
    chk("abort",  aborted,      m_abrt);
    chk("idx",    burst_idx,    m_idx);
`ifdef MTX_BURST_STATS_EN
    chk("stall",  stall_cnt,    m_stall);
`endif
    k++;
    if (busy && gen_srst) gapcyc++;
    if (done) dones++;
    if (aborted) aborts++;
    if (done && done_at == 0) done_at = k;
  endtask

  task automatic set_cfg(input int unsigned b, input int unsigned n, input int unsigned g);
    cfg_burst_len = 32'(b);
    cfg_n_bursts  = 16'(n);
    cfg_gap       = 24'(g);
  endtask

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_srst",   gen_srst, 1'b1);
    chk("rst_tvalid", phase_tvalid, 1'b0);
    chk("rst_idx",    burst_idx, 16'd0);

    // Three 4-beat bursts with a 2-cycle gap
    set_cfg(4, 3, 2);
    clear_stats();
    step(1, 0, 1, 1);
    for (int i = 0; i < 40 && done_at == 0; i++) step(0, 0, 1, 1);
    chk("t1_done_at", done_at, 17);
    chk("t1_beats",   beats, 12);
    chk("t1_lasts",   lasts, 3);
    chk("t1_gapcyc",  gapcyc, 4);

    // Single burst with alternating backpressure
    set_cfg(5, 1, 3);
    clear_stats();
    step(1, 0, 1, 0);
    for (int i = 0; i < 40 && done_at == 0; i++) step(0, 0, 1, (i % 2) == 0);
    chk("t2_done_at", done_at, 10);
    chk("t2_beats",   beats, 5);
    chk("t2_lasts",   lasts, 1);
`ifdef MTX_BURST_STATS_EN
    chk("t2_stall_cnt", stall_cnt, 4);
`endif

    // Abort during beat 3 of burst 0
    set_cfg(8, 2, 1);
    clear_stats();
    step(1, 0, 1, 1);
    for (int i = 0; i < 30 && done_at == 0 && aborts == 0; i++) step(0, i == 2, 1, 1);
    chk("t3_beats",  beats, 4);
    chk("t3_lasts",  lasts, 1);
    chk("t3_aborts", aborts, 1);
    chk("t3_dones",  dones, 0);

    // Ignored starts
    set_cfg(0, 2, 1);
    step(1, 0, 1, 1);
    chk("t4_b0_busy", busy, 1'b0);
    set_cfg(3, 0, 1);
    step(1, 0, 1, 1);
    chk("t4_n0_busy", busy, 1'b0);
    set_cfg(3, 1, 0);
    step(1, 1, 1, 1);
    step(0, 0, 1, 1);
    chk("t4_sa_busy", busy, 1'b0);
    clear_stats();
    step(1, 0, 1, 1);
    set_cfg(6, 3, 2);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    for (int i = 0; i < 20 && done_at == 0; i++) step(0, 0, 1, 1);
    chk("t4_beats", beats, 3);
    chk("t4_dones", dones, 1);

    // Zero gap still gives one srst cycle
    set_cfg(2, 2, 0);
    clear_stats();
    step(1, 0, 1, 1);
    for (int i = 0; i < 20 && done_at == 0; i++) step(0, 0, 1, 1);
    chk("t5_done_at", done_at, 6);
    chk("t5_gapcyc",  gapcyc, 1);
    chk("t5_beats",   beats, 4);

    // Reset in the middle of a burst
    set_cfg(6, 2, 1);
    clear_stats();
    step(1, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("t5_rst_tvalid", phase_tvalid, 1'b0);
    chk("t5_rst_srst",   gen_srst, 1'b1);
    step(0, 0, 1, 1);
    chk("t5_rst_pulses", dones + aborts, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      set_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
